// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a 32x32 sprite from ROM into a frame buffer with clipping,
// transparency and horizontal mirroring, or fills the whole frame buffer with one colour.
module sprite_blitter #(
    parameter int         SPR_DIM = 32,
    parameter int         SCR_W   = 640,
    parameter int         SCR_H   = 480,
    parameter logic [4:0] TRANSP  = 5'h00
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           start,
    input  logic [9:0]                     spriteX,
    input  logic [9:0]                     spriteY,
    input  logic [2:0]                     spriteId,
    input  logic                           flipH,
    input  logic                           clearReq,
    input  logic [4:0]                     clearColor,
    output logic [2+2*$clog2(SPR_DIM):0]   romAddr,
    input  logic [4:0]                     romData,
    output logic [18:0]                    fbAddr,
    output logic [4:0]                     fbData,
    output logic                           fbWe,
    output logic                           busy,
    output logic                           done
);

    localparam int              CW       = $clog2(SPR_DIM);
    localparam logic [CW-1:0]   CMAX     = CW'(SPR_DIM - 1);
    localparam logic [CW-1:0]   CZERO    = CW'(0);
    localparam logic [18:0]     CLR_LAST = 19'(SCR_W * SCR_H - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_BLIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_s;

    logic [9:0]             x_r;
    logic [9:0]             y_r;
    logic [2:0]             id_r;
    logic                   flip_r;
    logic [CW-1:0]          row_r;
    logic [CW-1:0]          col_r;
    logic [2+2*CW:0]        rom_addr_r;
    logic [18:0]            fb_addr_r;
    logic [4:0]             fb_data_r;
    logic                   fb_we_r;
    logic                   src_rom_r;
    logic                   busy_r;
    logic                   done_r;

    logic                   last_pix_s;
    logic [CW-1:0]          nxt_col_s;
    logic [CW-1:0]          nxt_row_s;
    logic [CW-1:0]          rom_col_s;
    logic [10:0]            x_s;
    logic [10:0]            y_s;
    logic                   in_bounds_s;
    logic [31:0]            pix_lin_s;
    logic [18:0]            pix_addr_s;

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a clear request takes priority over a blit request
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (clearReq) begin
                    state_s = S_CLEAR;
                end else if (start) begin
                    state_s = S_BLIT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (fb_addr_r == CLR_LAST) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_CLEAR;
                end
            end
            S_BLIT: begin
                if (last_pix_s) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_BLIT;
                end
            end
            S_DRAIN: state_s = S_DONE;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Sprite walk: next pixel, mirrored ROM column and screen coordinates of the current pixel
    always_comb begin
        last_pix_s  = (row_r == CMAX) && (col_r == CMAX);
        nxt_col_s   = col_r + CW'(1);
        if (col_r == CMAX) begin
            nxt_row_s = row_r + CW'(1);
        end else begin
            nxt_row_s = row_r;
        end
        if (flip_r) begin
            rom_col_s = ~nxt_col_s;
        end else begin
            rom_col_s = nxt_col_s;
        end
        x_s         = {1'b0, x_r} + 11'(col_r);
        y_s         = {1'b0, y_r} + 11'(row_r);
        in_bounds_s = (x_s < 11'(SCR_W)) && (y_s < 11'(SCR_H));
        pix_lin_s   = 32'(y_s) * 32'(SCR_W) + 32'(x_s);
        pix_addr_s  = 19'(pix_lin_s);
    end

    // Datapath: operand capture, counters, ROM address and pending frame-buffer write
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            x_r        <= 10'd0;
            y_r        <= 10'd0;
            id_r       <= 3'd0;
            flip_r     <= 1'b0;
            row_r      <= CZERO;
            col_r      <= CZERO;
            rom_addr_r <= '0;
            fb_addr_r  <= 19'd0;
            fb_data_r  <= 5'd0;
            fb_we_r    <= 1'b0;
            src_rom_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            busy_r <= (state_s != S_IDLE);
            done_r <= (state_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    fb_we_r   <= 1'b0;
                    src_rom_r <= 1'b0;
                    if (clearReq) begin
                        fb_addr_r <= 19'd0;
                        fb_data_r <= clearColor;
                        fb_we_r   <= 1'b1;
                    end else if (start) begin
                        x_r        <= spriteX;
                        y_r        <= spriteY;
                        id_r       <= spriteId;
                        flip_r     <= flipH;
                        row_r      <= CZERO;
                        col_r      <= CZERO;
                        rom_addr_r <= {spriteId, CZERO, (flipH ? CMAX : CZERO)};
                        src_rom_r  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (fb_addr_r == CLR_LAST) begin
                        fb_we_r <= 1'b0;
                    end else begin
                        fb_addr_r <= fb_addr_r + 19'd1;
                    end
                end
                S_BLIT: begin
                    // The write for this pixel is issued next cycle, when its ROM data arrives
                    fb_we_r    <= in_bounds_s;
                    fb_addr_r  <= pix_addr_s;
                    col_r      <= nxt_col_s;
                    row_r      <= nxt_row_s;
                    rom_addr_r <= {id_r, nxt_row_s, rom_col_s};
                end
                S_DRAIN: begin
                    fb_we_r   <= 1'b0;
                    src_rom_r <= 1'b0;
                end
                S_DONE: begin
                    fb_we_r   <= 1'b0;
                    src_rom_r <= 1'b0;
                end
                default: begin
                    fb_we_r   <= 1'b0;
                    src_rom_r <= 1'b0;
                end
            endcase
        end
    end

    // ROM data is only valid this cycle, so transparency gates the registered enable here
    assign fbWe    = fb_we_r & (~src_rom_r | (romData != TRANSP));
    assign fbData  = src_rom_r ? romData : fb_data_r;
    assign fbAddr  = fb_addr_r;
    assign romAddr = rom_addr_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized self-checking bench for sprite_blitter: a per-cycle expectation of every
// frame-buffer write, busy and done, built from the behavioural rules of each operation.
module tb_sprite_blitter;

    localparam int TW = 160;
    localparam int TH = 120;

    logic        Clk;
    logic        Reset_n;
    logic        start;
    logic [9:0]  spriteX;
    logic [9:0]  spriteY;
    logic [2:0]  spriteId;
    logic        flipH;
    logic        clearReq;
    logic [4:0]  clearColor;
    logic [12:0] romAddr;
    logic [4:0]  romData;
    logic [18:0] fbAddr;
    logic [4:0]  fbData;
    logic        fbWe;
    logic        busy;
    logic        done;

    sprite_blitter #(.SPR_DIM(32), .SCR_W(TW), .SCR_H(TH), .TRANSP(5'h00)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .spriteX(spriteX), .spriteY(spriteY),
        .spriteId(spriteId), .flipH(flipH), .clearReq(clearReq), .clearColor(clearColor),
        .romAddr(romAddr), .romData(romData), .fbAddr(fbAddr), .fbData(fbData),
        .fbWe(fbWe), .busy(busy), .done(done)
    );

    typedef struct {
        int         cyc;
        int         addr;
        logic [4:0] data;
    } wr_t;

    logic [4:0] rom   [0:8191];
    logic [4:0] fbmem [0:TW*TH-1];
    wr_t        q[$];
    int         cyc = 0;
    int         op_start = -10;
    int         op_done  = -10;
    int         compared = 0;
    int         mismatched = 0;
    int         wr_cnt = 0;
    int         last_done = -1;
    bit         chk_en = 1'b0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Synchronous ROM: data one cycle after the address
    always @(posedge Clk) romData <= rom[romAddr];

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the expected write list and busy/done window
    always @(negedge Clk) begin : cmp
        int c;
        if (chk_en) begin
            c = cyc;
            chk("busy", int'(busy), int'((c >= op_start) && (c <= op_done)));
            chk("done", int'(done), int'(c == op_done));
            if (done) last_done = c;
            while (q.size() > 0 && q[0].cyc < c) begin
                chk("missed_write_addr", -1, q[0].addr);
                void'(q.pop_front());
            end
            if (fbWe) begin
                wr_cnt++;
                if (int'(fbAddr) < TW*TH) fbmem[fbAddr] = fbData;
                if (q.size() > 0 && q[0].cyc == c) begin
                    chk("write_addr", int'(fbAddr), q[0].addr);
                    chk("write_data", int'(fbData), int'(q[0].data));
                    void'(q.pop_front());
                end else begin
                    chk("unexpected_write_addr", int'(fbAddr), -1);
                end
            end else if (q.size() > 0 && q[0].cyc == c) begin
                chk("absent_write_addr", -1, q[0].addr);
                void'(q.pop_front());
            end
        end
    end

    task automatic model_blit(input int p, input int x, input int y, input int id, input bit fl);
        int rc, px, py;
        wr_t w;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                rc = fl ? 31 - c : c;
                px = x + c;
                py = y + r;
                w.cyc  = p + 1 + r*32 + c;
                w.addr = py*TW + px;
                w.data = rom[id*1024 + r*32 + rc];
                if (w.data != 5'h00 && px < TW && py < TH) q.push_back(w);
            end
        end
        op_start = p;
        op_done  = p + 1025;
    endtask

    task automatic model_clear(input int p, input logic [4:0] col);
        wr_t w;
        for (int k = 0; k < TW*TH; k++) begin
            w.cyc  = p + k;
            w.addr = k;
            w.data = col;
            q.push_back(w);
        end
        op_start = p;
        op_done  = p + TW*TH;
    endtask

    // Present a request for one cycle; the model accepts it only if the DUT was idle
    task automatic issue(input bit clr, input bit st, input int x, input int y, input int id,
                         input bit fl, input logic [4:0] col, output int p);
        spriteX    = x[9:0];
        spriteY    = y[9:0];
        spriteId   = id[2:0];
        flipH      = fl;
        clearColor = col;
        start      = st;
        clearReq   = clr;
        @(posedge Clk);
        #1;
        p          = cyc;
        start      = 1'b0;
        clearReq   = 1'b0;
        spriteX    = 10'($urandom);
        spriteY    = 10'($urandom);
        spriteId   = 3'($urandom);
        flipH      = 1'($urandom);
        clearColor = 5'($urandom);
        if (p - 1 > op_done) begin
            wr_cnt = 0;
            if (clr) model_clear(p, col);
            else if (st) model_blit(p, x, y, id, fl);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30000 && cyc <= op_done; i++) tick(1);
        if (cyc <= op_done) begin
            chk("idle_timeout", cyc, op_done + 1);
            op_done = cyc - 2;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge Clk);
        chk({tag, "_romAddr"}, int'(romAddr), 0);
        chk({tag, "_fbAddr"}, int'(fbAddr), 0);
        chk({tag, "_fbData"}, int'(fbData), 0);
        chk({tag, "_fbWe"}, int'(fbWe), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        @(posedge Clk);
        #1;
    endtask

    task automatic fill_rom(input int zero_pct);
        for (int i = 0; i < 8192; i++) begin
            if (int'($urandom_range(0, 99)) < zero_pct) rom[i] = 5'h00;
            else rom[i] = 5'($urandom_range(1, 31));
        end
    endtask

    initial begin
        int p;
        Reset_n = 1'b0; start = 1'b0; clearReq = 1'b0; spriteX = 10'd0; spriteY = 10'd0;
        spriteId = 3'd0; flipH = 1'b0; clearColor = 5'd0;
        fill_rom(0);
        for (int i = 0; i < TW*TH; i++) fbmem[i] = 5'h1F;
        tick(3);
        Reset_n = 1'b1;
        check_reset_outputs("reset");
        chk_en = 1'b1;

        // Full clear with a simultaneous start; start and clear pulsed mid-clear are ignored
        issue(1'b1, 1'b1, 5, 5, 1, 1'b0, 5'h15, p);
        chk("clear_accepted", op_start, p);
        tick(5000);
        issue(1'b0, 1'b1, 10, 10, 2, 1'b0, 5'h03, p);
        tick(3000);
        issue(1'b1, 1'b0, 0, 0, 0, 1'b0, 5'h07, p);
        wait_idle();
        chk("clear_writes", wr_cnt, 19200);
        chk("clear_done_cycle", last_done - op_start, 19200);
        chk("clear_fb_first", int'(fbmem[0]), 5'h15);
        chk("clear_fb_last", int'(fbmem[TW*TH-1]), 5'h15);

        // Opaque sprite fully on screen
        fill_rom(0);
        issue(1'b0, 1'b1, 100, 50, 2, 1'b0, 5'h00, p);
        chk("blit_model_first_addr", q[0].addr, 8100);
        chk("blit_model_last_addr", q[q.size()-1].addr, 13091);
        chk("blit_model_first_data", int'(q[0].data), int'(rom[2048]));
        wait_idle();
        chk("blit_writes", wr_cnt, 1024);
        chk("blit_done_cycle", last_done - p, 1025);

        // Mirrored sprite at the origin with transparent pixels
        rom[31] = 5'h1A;
        rom[0]  = 5'h07;
        rom[5]  = 5'h00;
        tick(1);
        issue(1'b0, 1'b1, 0, 0, 0, 1'b1, 5'h00, p);
        wait_idle();
        chk("flip_addr0", int'(fbmem[0]), 5'h1A);
        chk("flip_addr31", int'(fbmem[31]), 5'h07);
        chk("flip_transparent", int'(fbmem[26]), 5'h15);

        // Clipped at the bottom-right corner
        issue(1'b0, 1'b1, TW-20, TH-10, 4, 1'b0, 5'h00, p);
        wait_idle();
        chk("clip_writes", wr_cnt, 200);
        chk("clip_done_cycle", last_done - p, 1025);

        // Reset in the middle of a blit, then a normal blit
        issue(1'b0, 1'b1, 50, 20, 3, 1'b1, 5'h00, p);
        tick(499);
        Reset_n = 1'b0;
        @(posedge Clk);
        #1;
        q.delete();
        op_start = -10;
        op_done  = -10;
        Reset_n  = 1'b1;
        check_reset_outputs("midreset");
        tick(2);
        issue(1'b0, 1'b1, 7, 9, 5, 1'b0, 5'h00, p);
        chk("after_reset_accepted", op_start, p);
        wait_idle();
        chk("after_reset_writes", wr_cnt, 1024);

        // Randomized blits, back to back
        for (int n = 0; n < 12; n++) begin
            fill_rom(25);
            if ($urandom_range(0, 3) == 0)
                issue(1'b0, 1'b1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 7)), 1'($urandom), 5'h00, p);
            else
                issue(1'b0, 1'b1, int'($urandom_range(0, TW)), int'($urandom_range(0, TH)),
                      int'($urandom_range(0, 7)), 1'($urandom), 5'h00, p);
            wait_idle();
            chk("rand_done_cycle", last_done - p, 1025);
        end
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
